// File: rtl/lfm_nco.sv
// lfm_nco: burst quadrature waveform generator (CW or linear-FM chirp).
// One pulse of pulse_len sine/cosine samples is produced per accepted start.
// Pipeline: phase issue -> table address register -> table read -> output
// register, so sample k appears three cycles after it is issued.
module lfm_nco #(
    parameter int PHASE_WIDTH = 32,
    parameter int DATA_WIDTH  = 12,
    parameter int LUT_AW      = 10,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          mode,
    input  logic [PHASE_WIDTH-1:0]        start_freq,
    input  logic [PHASE_WIDTH-1:0]        chirp_rate,
    input  logic [PHASE_WIDTH-1:0]        phase_offset,
    input  logic [LEN_WIDTH-1:0]          pulse_len,
    output logic signed [DATA_WIDTH-1:0]  sine_out,
    output logic signed [DATA_WIDTH-1:0]  cosine_out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int LUT_DEPTH = 1 << LUT_AW;
    localparam logic [LUT_AW-1:0] QUARTER = LUT_AW'(LUT_DEPTH / 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Table entry: round-half-away-from-zero of A*sin(2*pi*a/N), evaluated at
    // elaboration with a Taylor series on the angle folded into [-pi, pi].
    function automatic logic signed [DATA_WIDTH-1:0] sine_entry(input int a);
        real pi_c;
        real x;
        real term;
        real sum;
        real amp;
        real v;
        int  r;
        pi_c = 3.14159265358979323846;
        if (a > LUT_DEPTH / 2)
            x = 2.0 * pi_c * real'(a - LUT_DEPTH) / real'(LUT_DEPTH);
        else
            x = 2.0 * pi_c * real'(a) / real'(LUT_DEPTH);
        term = x;
        sum  = x;
        for (int n = 1; n < 20; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            sum  = sum + term;
        end
        amp = real'((1 << (DATA_WIDTH - 1)) - 1);
        v   = amp * sum;
        if (v >= 0.0)
            r = $rtoi(v + 0.5);
        else
            r = -$rtoi(-v + 0.5);
        return DATA_WIDTH'(r);
    endfunction

    // Full-cycle sine table; cosine reads the same table a quarter turn ahead.
    logic signed [DATA_WIDTH-1:0] sin_rom [LUT_DEPTH];

    for (genvar gi = 0; gi < LUT_DEPTH; gi++) begin : g_rom
        assign sin_rom[gi] = sine_entry(gi);
    end

    state_t                       state_reg;
    logic                         mode_reg;
    logic [PHASE_WIDTH-1:0]       phase_reg;
    logic [PHASE_WIDTH-1:0]       freq_reg;
    logic [PHASE_WIDTH-1:0]       chirp_reg;
    logic [LEN_WIDTH-1:0]         cnt_reg;

    logic                         s1_valid_reg;
    logic                         s1_last_reg;
    logic [LUT_AW-1:0]            s1_addr_reg;
    logic [LUT_AW-1:0]            cos_addr;

    logic                         s2_valid_reg;
    logic                         s2_last_reg;
    logic signed [DATA_WIDTH-1:0] s2_sin_reg;
    logic signed [DATA_WIDTH-1:0] s2_cos_reg;

    assign cos_addr = s1_addr_reg + QUARTER;

    // Control FSM plus phase/frequency accumulators; issues one table address per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            mode_reg     <= 1'b0;
            phase_reg    <= '0;
            freq_reg     <= '0;
            chirp_reg    <= '0;
            cnt_reg      <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_addr_reg  <= '0;
            busy         <= 1'b0;
        end else if (abort) begin
            state_reg    <= IDLE;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && (pulse_len != '0)) begin
                        mode_reg  <= mode;
                        phase_reg <= phase_offset;
                        freq_reg  <= start_freq;
                        chirp_reg <= chirp_rate;
                        cnt_reg   <= pulse_len;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    s1_valid_reg <= 1'b1;
                    s1_last_reg  <= (cnt_reg == LEN_WIDTH'(1));
                    s1_addr_reg  <= phase_reg[PHASE_WIDTH-1 -: LUT_AW];
                    phase_reg    <= phase_reg + freq_reg;
                    if (mode_reg)
                        freq_reg <= freq_reg + chirp_reg;
                    cnt_reg      <= cnt_reg - LEN_WIDTH'(1);
                    if (cnt_reg == LEN_WIDTH'(1))
                        state_reg <= DRAIN;
                end
                DRAIN: begin
                    // Leave once the cycle carrying done has been presented.
                    if (done) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Registered table read (sine and quarter-shifted cosine) with its valid/last tags.
    always_ff @(posedge clk) begin
        s2_sin_reg <= sin_rom[s1_addr_reg];
        s2_cos_reg <= sin_rom[cos_addr];
        if (rst || abort) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            s2_last_reg  <= s1_last_reg;
        end
    end

    // Output register: samples are forced to zero whenever they are not valid.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            out_valid  <= 1'b0;
            done       <= 1'b0;
            sine_out   <= '0;
            cosine_out <= '0;
        end else begin
            out_valid  <= s2_valid_reg;
            done       <= s2_valid_reg && s2_last_reg;
            sine_out   <= s2_valid_reg ? s2_sin_reg : '0;
            cosine_out <= s2_valid_reg ? s2_cos_reg : '0;
        end
    end

endmodule

// File: tb/tb_lfm_nco.sv
// tb_lfm_nco: directed bench for lfm_nco with a closed-form waveform model
// and a per-cycle compare process.
module tb_lfm_nco;

    localparam int PW = 32;
    localparam int DW = 12;
    localparam int AW = 10;
    localparam int LW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 mode = 1'b0;
    logic [PW-1:0]        start_freq = '0;
    logic [PW-1:0]        chirp_rate = '0;
    logic [PW-1:0]        phase_offset = '0;
    logic [LW-1:0]        pulse_len = '0;
    logic signed [DW-1:0] sine_out;
    logic signed [DW-1:0] cosine_out;
    logic                 out_valid;
    logic                 busy;
    logic                 done;

    lfm_nco #(
        .PHASE_WIDTH (PW),
        .DATA_WIDTH  (DW),
        .LUT_AW      (AW),
        .LEN_WIDTH   (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .start_freq   (start_freq),
        .chirp_rate   (chirp_rate),
        .phase_offset (phase_offset),
        .pulse_len    (pulse_len),
        .sine_out     (sine_out),
        .cosine_out   (cosine_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // cyc == n between edge n and edge n+1
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int s;
        int c;
        bit last;
    } exp_t;

    exp_t q[$];
    int   busy_from  = 1;
    int   busy_until = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   valid_cnt  = 0;
    int   done_cnt   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Ideal quantised sine at table index a.
    function automatic int ref_sin(input int a);
        real v;
        v = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 1024.0);
        return $rtoi($floor(v + 0.5));
    endfunction

    // Closed form: phase_k = po + k*sf + cr*k*(k-1)/2 (chirp term only in LFM).
    function automatic logic [31:0] model_phase(input logic [31:0] po, input logic [31:0] sf,
                                                input logic [31:0] cr, input bit m, input int k);
        logic [63:0] kk;
        logic [63:0] tri_n;
        logic [63:0] acc;
        kk    = 64'(k);
        tri_n = (k > 0) ? (kk * (kk - 64'd1)) / 64'd2 : 64'd0;
        acc   = 64'(po) + kk * 64'(sf) + (m ? tri_n * 64'(cr) : 64'd0);
        return acc[31:0];
    endfunction

    // Drop any expected work that an abort/reset sampled at edge c+1 kills.
    task automatic flush(input int c);
        while (q.size() > 0 && q[q.size()-1].cyc > c) void'(q.pop_back());
        if (busy_until > c) busy_until = c;
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one start request for a cycle; model decides acceptance. e = accepting edge or -1.
    task automatic pulse_req(input bit m, input logic [31:0] sf, input logic [31:0] cr,
                             input logic [31:0] po, input int len, input bit with_abort,
                             output int e);
        int c;
        logic [31:0] p;
        int a;
        c = cyc;
        mode         = m;
        start_freq   = sf;
        chirp_rate   = cr;
        phase_offset = po;
        pulse_len    = LW'(len);
        start        = 1'b1;
        abort        = with_abort;
        e = -1;
        if (with_abort) begin
            flush(c);
        end else if (len != 0 && c > busy_until) begin
            e = c + 1;
            busy_from  = e;
            busy_until = e + 2 + len;
            for (int k = 0; k < len; k++) begin
                p = model_phase(po, sf, cr, m, k);
                a = int'(p[31:22]);
                q.push_back('{e + 3 + k, ref_sin(a), ref_sin((a + 256) % 1024), (k == len - 1)});
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        $display("start req cycle %0d mode=%0d sf=%0d cr=%h po=%h len=%0d abort=%0d -> %s",
                 c, m, sf, cr, po, len, with_abort, (e >= 0) ? "accepted" : "ignored");
    endtask

    int   ev_s, ev_c;
    bit   ev_v, ev_d, ev_b;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            ev_v = 1'b0;
            ev_s = 0;
            ev_c = 0;
            ev_d = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                ev_v = 1'b1;
                ev_s = q[0].s;
                ev_c = q[0].c;
                ev_d = q[0].last;
                void'(q.pop_front());
            end
            ev_b = (cyc >= busy_from) && (cyc <= busy_until);
            check("out_valid", int'(out_valid), int'(ev_v));
            check("sine_out", int'(sine_out), ev_s);
            check("cosine_out", int'(cosine_out), ev_c);
            check("done", int'(done), int'(ev_d));
            check("busy", int'(busy), int'(ev_b));
            if (out_valid === 1'b1) valid_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        int e;
        int e2;
        int v0;
        int d0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valid", int'(out_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_sine", int'(sine_out), 0);

        // Hand-computed pins on the model itself
        check("model_sin0", ref_sin(0), 0);
        check("model_sin256", ref_sin(256), 2047);
        check("model_sin768", ref_sin(768), -2047);
        check("model_sin128", ref_sin(128), 1447);
        check("model_sin1", ref_sin(1), 13);
        check("model_phase_cw25", int'(model_phase(32'd0, 32'd42949673, 32'd0, 1'b0, 25)), 1073741825);
        check("model_phase_lfm3", int'(model_phase(32'd0, 32'd0, 32'h0040_0000, 1'b1, 3)), 12582912);

        // 1: CW 1 MHz
        goto(cyc + 2);
        pulse_req(1'b0, 32'd42949673, 32'd0, 32'd0, 200, 1'b0, e);
        v0 = valid_cnt;
        d0 = done_cnt;
        goto(e + 2);
        check("cw_pre_valid", int'(out_valid), 0);
        goto(e + 3);
        check("cw_s0_valid", int'(out_valid), 1);
        check("cw_s0_sin", int'(sine_out), 0);
        check("cw_s0_cos", int'(cosine_out), 2047);
        goto(e + 28);
        check("cw_s25_sin", int'(sine_out), 2047);
        goto(e + 202);
        check("cw_done", int'(done), 1);
        goto(e + 203);
        check("cw_busy_fall", int'(busy), 0);
        check("cw_valid_count", valid_cnt - v0, 200);
        check("cw_done_count", done_cnt - d0, 1);

        // 2: phase offset of a quarter turn
        pulse_req(1'b0, 32'd0, 32'd0, 32'h4000_0000, 4, 1'b0, e);
        goto(e + 3);
        check("ofs_sin", int'(sine_out), 2047);
        check("ofs_cos", int'(cosine_out), 0);
        goto(e + 6);
        check("ofs_last_sin", int'(sine_out), 2047);
        check("ofs_done", int'(done), 1);
        goto(e + 8);

        // 3: LFM up-chirp then down-chirp
        pulse_req(1'b1, 32'd0, 32'h0040_0000, 32'd0, 1024, 1'b0, e);
        goto(e + 5);
        check("lfm_up_k2_sin", int'(sine_out), 13);
        check("lfm_up_k2_cos", int'(cosine_out), 2047);
        goto(e + 3 + 1024 + 1);
        pulse_req(1'b1, 32'd0, 32'hFFC0_0000, 32'd0, 1024, 1'b0, e);
        goto(e + 5);
        check("lfm_dn_k2_sin", int'(sine_out), -13);
        goto(e + 3 + 1024 + 1);

        // 4: start while busy, then zero length
        pulse_req(1'b0, 32'd100000000, 32'd0, 32'd0, 50, 1'b0, e);
        v0 = valid_cnt;
        d0 = done_cnt;
        goto(e + 9);
        pulse_req(1'b1, 32'h0123_4567, 32'h0000_0100, 32'd0, 77, 1'b0, e2);
        goto(e + 3 + 50 + 12);
        check("busy_start_valids", valid_cnt - v0, 50);
        check("busy_start_dones", done_cnt - d0, 1);
        v0 = valid_cnt;
        d0 = done_cnt;
        pulse_req(1'b0, 32'd5, 32'd0, 32'd0, 0, 1'b0, e2);
        goto(cyc + 10);
        check("zero_len_valids", valid_cnt - v0, 0);
        check("zero_len_dones", done_cnt - d0, 0);
        check("zero_len_busy", int'(busy), 0);

        // 5a: abort at sample 20
        pulse_req(1'b0, 32'd85899346, 32'd0, 32'h1000_0000, 100, 1'b0, e);
        d0 = done_cnt;
        goto(e + 23);
        abort = 1'b1;
        flush(cyc);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_valid", int'(out_valid), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_sine", int'(sine_out), 0);
        check("abort_done", int'(done), 0);
        pulse_req(1'b1, 32'd10000000, 32'd5000, 32'd7, 40, 1'b0, e);
        v0 = valid_cnt;
        goto(e + 3 + 40 + 1);
        check("after_abort_valids", valid_cnt - v0, 40);
        check("after_abort_dones", done_cnt - d0, 1);

        // 5b: reset mid-pulse
        pulse_req(1'b0, 32'd30000000, 32'd0, 32'h0800_0000, 60, 1'b0, e);
        d0 = done_cnt;
        goto(e + 30);
        rst = 1'b1;
        flush(cyc);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cosine", int'(cosine_out), 0);
        pulse_req(1'b0, 32'd70000000, 32'd0, 32'd0, 25, 1'b0, e);
        v0 = valid_cnt;
        goto(e + 3 + 25 + 1);
        check("after_rst_valids", valid_cnt - v0, 25);
        check("after_rst_dones", done_cnt - d0, 1);

        // 5c: abort together with start
        v0 = valid_cnt;
        d0 = done_cnt;
        pulse_req(1'b0, 32'd1000, 32'd0, 32'd0, 10, 1'b1, e2);
        goto(cyc + 15);
        check("abort_start_valids", valid_cnt - v0, 0);
        check("abort_start_dones", done_cnt - d0, 0);

        // 6: back-to-back, second start in the first IDLE cycle after done
        v0 = valid_cnt;
        d0 = done_cnt;
        pulse_req(1'b1, 32'd20000000, 32'hFFF0_0000, 32'h8000_0000, 20, 1'b0, e);
        goto(e + 23);
        pulse_req(1'b0, 32'd300000000, 32'd0, 32'h2000_0000, 15, 1'b0, e2);
        goto(e + 26);
        check("b2b_gap_valid", int'(out_valid), 0);
        goto(e + 27);
        check("b2b_first_sin", int'(sine_out), 1447);
        check("b2b_first_cos", int'(cosine_out), 1447);
        goto(e + 27 + 15 + 1);
        check("b2b_valids", valid_cnt - v0, 35);
        check("b2b_dones", done_cnt - d0, 2);

        goto(cyc + 5);
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfm_nco.md
Name: lfm_nco

Overview:
Parametrised successor to the free-running NCO. It generates one burst of quadrature samples (sine/cosine) per start request, either constant-frequency (CW) or linear-FM chirp, with programmable start frequency, chirp rate, initial phase and pulse length. It is the transmit/reference waveform source for the pulse-compression chain and feeds the matched-filter reference and the DAC path.

Parameters:
PHASE_WIDTH, 32, width of phase and frequency accumulators (modulo 2^PHASE_WIDTH)
DATA_WIDTH, 12, signed output sample width
LUT_AW, 10, phase bits used to address the sine table (table has 2^LUT_AW points per cycle)
LEN_WIDTH, 16, width of pulse length counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a pulse; sampled only in IDLE
abort  in  1  synchronous pulse abort
mode  in  1  0 = CW, 1 = LFM; latched on accepted start
start_freq  in  PHASE_WIDTH  initial phase increment (unsigned); latched on start
chirp_rate  in  PHASE_WIDTH  signed per-sample increment of the frequency word; latched on start
phase_offset  in  PHASE_WIDTH  initial phase; latched on start
pulse_len  in  LEN_WIDTH  number of samples in the pulse; latched on start
sine_out  out  DATA_WIDTH  signed sine sample
cosine_out  out  DATA_WIDTH  signed cosine sample
out_valid  out  1  sample valid
busy  out  1  pulse in progress
done  out  1  one-cycle pulse, coincident with the last valid sample

Behaviour:
- Reset: all outputs 0, FSM in IDLE, accumulators 0, pipeline valids cleared. Reset mid-pulse aborts the pulse immediately. No done is produced.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start=1 with pulse_len != 0. Inputs are latched on that edge. start with pulse_len=0 is ignored: no busy, no valid, no done.
- start received while busy=1 is ignored.
- RUN issues one phase per cycle for pulse_len cycles, then moves to DRAIN.
- DRAIN lasts until the pipeline empties, then returns to IDLE.
- busy is high from the cycle after an accepted start through the cycle carrying done.
- Sample k (k = 0..pulse_len-1):
  - phase_k = phase_offset + sum over i<k of freq_i
  - freq_i = start_freq + i*chirp_rate in LFM mode; freq_i = start_freq in CW mode.
  - All sums are modulo 2^PHASE_WIDTH, so wrap-around is silent. chirp_rate is two's complement, so down-chirps are supported.
- Latency: if start is accepted at edge T, sample k is presented with out_valid=1 in cycle T+3+k. out_valid stays high for exactly pulse_len consecutive cycles.
- done=1 only with sample pulse_len-1.
- Table addressing: the address a is the top LUT_AW bits of the phase.
  - Sine table: sin value = round(A*sin(2*pi*a/2^LUT_AW)), where A = 2^(DATA_WIDTH-1)-1 (2047 at default).
  - Cosine uses address a + 2^(LUT_AW-2), i.e. +90 degrees.
  - A quarter-wave table with symmetry folding is permitted only if it is bit-exact to the full-table definition.
  - Output never reaches -2^(DATA_WIDTH-1).
- When out_valid=0, sine_out and cosine_out are held at 0.
- abort=1 (any state):
  - next cycle: FSM in IDLE, all pipeline valids cleared, out_valid=0, busy=0, no done.
  - abort and start in the same cycle: abort wins and start is dropped.
- Back-to-back pulses: a start is accepted in the first IDLE cycle after done. The minimum gap between pulses is therefore 1 idle cycle plus latency.

Test Plan:
1. CW 1 MHz @ 100 MHz clock:
   - Stimulus: mode=0, start_freq=42949673, phase_offset=0, pulse_len=200, start at T.
   - Required: out_valid at T+3..T+202; first sample sin=0, cos=2047; sample 25 sin≈2047; sine period 100 samples; done at T+202 only; busy falls after T+202.
2. Phase offset:
   - Stimulus: phase_offset=2^30, start_freq=0, pulse_len=4.
   - Required: all 4 samples sin=2047, cos=0.
3. LFM:
   - Stimulus: mode=1, start_freq=0, chirp_rate=2^22, pulse_len=1024.
   - Required: phase_k = 2^22*k*(k-1)/2 mod 2^32; bench compares all samples bit-exactly against the table model. A repeat with chirp_rate=-2^22 checks the down-chirp.
4. Start while busy and zero length:
   - Stimulus: a second start at T+10 during a 50-sample pulse; separately, start with pulse_len=0.
   - Required: exactly 50 valids and one done; the zero-length start produces no busy, valid or done.
5. Abort and reset:
   - Stimulus: abort at sample 20 of a 100-sample pulse; separately, rst mid-pulse; separately, abort with start in the same cycle.
   - Required: out_valid, busy and outputs are 0 the next cycle, no done, and the FSM is in IDLE. A fresh start then yields a full, correct pulse.
6. Back-to-back:
   - Stimulus: start asserted in the first IDLE cycle after done.
   - Required: second pulse accepted and bit-exact, with no residual samples from the first pulse.
